// File: rtl/branch_predictor_bht_if.sv
// Predictor bus: fetch-side prediction, EX-side training inputs and statistics.
//   master: drives pred_en, bht_clear, if_pc, ex_pc, branch, actual_pcsrc, update;
//           observes predict_pcsrc, br_count, mispredict_count.
//   slave : the predictor itself (mirror directions).
interface branch_predictor_bht_if #(
  parameter int unsigned CNT_W = 32
);
  logic             pred_en;
  logic             bht_clear;
  logic [31:0]      if_pc;
  logic             predict_pcsrc;
  logic [31:0]      ex_pc;
  logic             branch;
  logic             actual_pcsrc;
  logic             update;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output pred_en, bht_clear, if_pc, ex_pc, branch, actual_pcsrc, update,
    input  predict_pcsrc, br_count, mispredict_count
  );

  modport slave (
    input  pred_en, bht_clear, if_pc, ex_pc, branch, actual_pcsrc, update,
    output predict_pcsrc, br_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_bht.sv
// Branch history table of 2-bit saturating counters indexed by PC[IDX_W+1:2].
// Prediction for the fetch PC is combinational from registered table state;
// training and statistics happen on resolved EX branches.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of branch_predictor_bht_if
module branch_predictor_bht #(
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned CNT_W      = 32,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predictor_bht_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [1:0]       bht_q [DEPTH];
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mispredict_count_q;

  logic [IDX_W-1:0] rd_idx_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic             train_c;
  logic [1:0]       ctr_next_c;

  // Untagged direct-mapped indexing; PC upper bits and byte offset are don't-care.
  assign rd_idx_c = bus.if_pc[IDX_W+1:2];
  assign wr_idx_c = bus.ex_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0],
                            bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};

  assign train_c = bus.pred_en & bus.branch & ~bus.bht_clear;

  // Saturating up/down step of the counter being trained.
  always_comb begin
    ctr_next_c = bht_q[wr_idx_c];
    if (bus.actual_pcsrc) begin
      if (bht_q[wr_idx_c] != 2'b11) ctr_next_c = bht_q[wr_idx_c] + 2'(1);
    end else begin
      if (bht_q[wr_idx_c] != 2'b00) ctr_next_c = bht_q[wr_idx_c] - 2'(1);
    end
  end

  // Counter table; clear wins over a same-cycle training write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) bht_q[i] <= INIT_STATE;
    end else if (bus.bht_clear) begin
      for (int i = 0; i < int'(DEPTH); i++) bht_q[i] <= INIT_STATE;
    end else if (train_c) begin
      bht_q[wr_idx_c] <= ctr_next_c;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q         <= '0;
      mispredict_count_q <= '0;
    end else if (bus.bht_clear) begin
      br_count_q         <= '0;
      mispredict_count_q <= '0;
    end else if (train_c) begin
      if (br_count_q != '1) br_count_q <= br_count_q + CNT_W'(1);
      if (bus.update && (mispredict_count_q != '1))
        mispredict_count_q <= mispredict_count_q + CNT_W'(1);
    end
  end

  // Read sees registered contents only: no same-cycle write bypass.
  assign bus.predict_pcsrc    = bus.pred_en & bht_q[rd_idx_c][1];
  assign bus.br_count         = br_count_q;
  assign bus.mispredict_count = mispredict_count_q;
endmodule
